// File: rtl/apb_to_axi_lite_bridge.sv
// APB4 completer to AXI4-Lite manager bridge, one transaction in flight.
// Latency: APB access at t0 -> AXI valid at t1 -> pready one cycle after the B/R handshake (t3 minimum).
// Backpressure: APB is held via pready; AXI valids stay up until their ready, B/R accepted only when expected.
module apb_to_axi_lite_bridge #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // APB4 completer
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [2:0]           pprot_i,
    input  logic [DataWidth-1:0] pwdata_i,
    input  logic [StrbWidth-1:0] pstrb_i,
    output logic                 pready_o,
    output logic [DataWidth-1:0] prdata_o,
    output logic                 pslverr_o,
    // AXI4-Lite write address
    output logic [AddrWidth-1:0] aw_addr_o,
    output logic [2:0]           aw_prot_o,
    output logic                 aw_valid_o,
    input  logic                 aw_ready_i,
    // AXI4-Lite write data
    output logic [DataWidth-1:0] w_data_o,
    output logic [StrbWidth-1:0] w_strb_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    // AXI4-Lite write response
    input  logic [1:0]           b_resp_i,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    // AXI4-Lite read address
    output logic [AddrWidth-1:0] ar_addr_o,
    output logic [2:0]           ar_prot_o,
    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    // AXI4-Lite read data
    input  logic [DataWidth-1:0] r_data_i,
    input  logic [1:0]           r_resp_i,
    input  logic                 r_valid_i,
    output logic                 r_ready_o
);

    if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_data_width
        $error("apb_to_axi_lite_bridge: DataWidth must be 32 or 64");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_hs;
    logic   w_hs;
    logic   ar_hs;

    assign aw_hs = aw_valid_o & aw_ready_i;
    assign w_hs  = w_valid_o & w_ready_i;
    assign ar_hs = ar_valid_o & ar_ready_i;

    // Only bit 1 of the AXI response matters: SLVERR and DECERR both map to pslverr.
    logic unused_resp_bits;
    assign unused_resp_bits = b_resp_i[0] ^ r_resp_i[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            pready_o   <= 1'b0;
            prdata_o   <= '0;
            pslverr_o  <= 1'b0;
            aw_addr_o  <= '0;
            aw_prot_o  <= '0;
            aw_valid_o <= 1'b0;
            w_data_o   <= '0;
            w_strb_o   <= '0;
            w_valid_o  <= 1'b0;
            b_ready_o  <= 1'b0;
            ar_addr_o  <= '0;
            ar_prot_o  <= '0;
            ar_valid_o <= 1'b0;
            r_ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Setup phase is ignored; only the access phase launches AXI traffic.
                    if (psel_i && penable_i) begin
                        if (pwrite_i) begin
                            aw_addr_o  <= paddr_i;
                            aw_prot_o  <= pprot_i;
                            w_data_o   <= pwdata_i;
                            w_strb_o   <= pstrb_i;
                            aw_valid_o <= 1'b1;
                            w_valid_o  <= 1'b1;
                            state      <= WR_REQ;
                        end else begin
                            ar_addr_o  <= paddr_i;
                            ar_prot_o  <= pprot_i;
                            ar_valid_o <= 1'b1;
                            state      <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        aw_valid_o <= 1'b0;
                        aw_done    <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_o <= 1'b0;
                        w_done    <= 1'b1;
                    end
                    // Handshakes completing this cycle count alongside earlier ones.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        b_ready_o <= 1'b1;
                        state     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_valid_i && b_ready_o) begin
                        b_ready_o <= 1'b0;
                        pready_o  <= 1'b1;
                        prdata_o  <= '0;
                        pslverr_o <= b_resp_i[1];
                        state     <= DONE;
                    end
                end
                RD_REQ: begin
                    if (ar_hs) begin
                        ar_valid_o <= 1'b0;
                        r_ready_o  <= 1'b1;
                        state      <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_valid_i && r_ready_o) begin
                        r_ready_o <= 1'b0;
                        pready_o  <= 1'b1;
                        prdata_o  <= r_data_i;
                        pslverr_o <= r_resp_i[1];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Single-cycle completion; no new access is taken until back in IDLE.
                    pready_o  <= 1'b0;
                    prdata_o  <= '0;
                    pslverr_o <= 1'b0;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_to_axi_lite_bridge.sv
// Bench for apb_to_axi_lite_bridge: directed scenarios plus randomized transfers,
// checked against a cycle-level model of when each channel should be active.
module tb_apb_to_axi_lite_bridge;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int MAXCYC = 60;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          psel_i, penable_i, pwrite_i;
    logic [AW-1:0] paddr_i;
    logic [2:0]    pprot_i;
    logic [DW-1:0] pwdata_i;
    logic [SW-1:0] pstrb_i;
    logic          pready_o;
    logic [DW-1:0] prdata_o;
    logic          pslverr_o;
    logic [AW-1:0] aw_addr_o;
    logic [2:0]    aw_prot_o;
    logic          aw_valid_o, aw_ready_i;
    logic [DW-1:0] w_data_o;
    logic [SW-1:0] w_strb_o;
    logic          w_valid_o, w_ready_i;
    logic [1:0]    b_resp_i;
    logic          b_valid_i, b_ready_o;
    logic [AW-1:0] ar_addr_o;
    logic [2:0]    ar_prot_o;
    logic          ar_valid_o, ar_ready_i;
    logic [DW-1:0] r_data_i;
    logic [1:0]    r_resp_i;
    logic          r_valid_i, r_ready_o;

    apb_to_axi_lite_bridge #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .paddr_i(paddr_i), .pprot_i(pprot_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
        .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
        .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Observations from the most recent transfer, indexed by cycle offset from the APB access cycle.
    logic [63:0] tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_pr;
    logic [DW-1:0] got_prdata;
    logic          got_pslverr;
    logic          post_pr, post_pslverr;
    logic [DW-1:0] post_prdata;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, drop_err;
    logic [AW-1:0] cap_aw_addr, cap_ar_addr;
    logic [2:0]    cap_aw_prot, cap_ar_prot;
    logic [DW-1:0] cap_w_data;
    logic [SW-1:0] cap_w_strb;

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i < 64) m[i] = 1'b1;
        return m;
    endfunction

    // Reference: each channel is busy from t1 until its handshake; a response is
    // taken rsp_dly cycles (at least one) after the request side finishes, and
    // pready follows the response handshake by one cycle.
    function automatic logic [383:0] model(input bit wr, input int aw_dly, input int w_dly,
                                           input int ar_dly, input int rsp_dly);
        int awh, wh, last, bh, arh, rh;
        if (wr) begin
            awh  = mx(1, aw_dly);
            wh   = mx(1, w_dly);
            last = mx(awh, wh);
            bh   = last + mx(1, rsp_dly);
            return {span(1, awh), span(1, wh), span(last + 1, bh), 64'd0, 64'd0, span(bh + 1, bh + 1)};
        end
        arh = mx(1, ar_dly);
        rh  = arh + mx(1, rsp_dly);
        return {64'd0, 64'd0, 64'd0, span(1, arh), span(arh + 1, rh), span(rh + 1, rh + 1)};
    endfunction

    task automatic clear_axi_inputs();
        aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0;
        b_valid_i  = 1'b0; b_resp_i  = 2'b00;
        r_valid_i  = 1'b0; r_resp_i  = 2'b00; r_data_i = '0;
    endtask

    // Called at a falling edge: drives setup, then access, then plays the AXI target.
    task automatic run_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic [2:0] prot,
                            input int aw_dly, input int w_dly, input int ar_dly, input int rsp_dly,
                            input logic [1:0] rsp, input logic [DW-1:0] rdat, input int abort_at);
        int aw_h, w_h, ar_h, last, pr_cyc;
        bit bdone, rdone;
        bit s_aw, s_w, s_b, s_ar, s_r;
        bit p_aw, p_w, p_ar, p_aw_hs, p_w_hs, p_ar_hs;
        tr_aw = '0; tr_w = '0; tr_b = '0; tr_ar = '0; tr_r = '0; tr_pr = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; drop_err = 0;
        got_prdata = 'x; got_pslverr = 1'bx;
        aw_h = -1; w_h = -1; ar_h = -1; pr_cyc = -1; bdone = 0; rdone = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr;
        pprot_i = prot; pwdata_i = data; pstrb_i = strb;
        @(negedge clk_i);
        penable_i = 1'b1;
        for (int n = 0; n < MAXCYC; n++) begin
            if (n > 0) begin
                @(negedge clk_i);
                pwdata_i = $urandom;
                pstrb_i  = SW'($urandom);
            end
            s_aw = aw_valid_o; s_w = w_valid_o; s_b = b_ready_o; s_ar = ar_valid_o; s_r = r_ready_o;
            tr_aw[n] = s_aw; tr_w[n] = s_w; tr_b[n] = s_b; tr_ar[n] = s_ar; tr_r[n] = s_r;
            tr_pr[n] = pready_o;
            if (n == abort_at) return;
            if (pready_o === 1'b1) begin
                pr_cyc = n; got_prdata = prdata_o; got_pslverr = pslverr_o;
                break;
            end
            if ((p_aw && !p_aw_hs && !s_aw) || (p_w && !p_w_hs && !s_w) || (p_ar && !p_ar_hs && !s_ar))
                drop_err++;
            aw_ready_i = (n >= aw_dly);
            w_ready_i  = (n >= w_dly);
            ar_ready_i = (n >= ar_dly);
            last       = (aw_h >= 0 && w_h >= 0) ? mx(aw_h, w_h) : -1;
            b_valid_i  = wr && last >= 0 && !bdone && (n >= last + rsp_dly);
            b_resp_i   = rsp;
            r_valid_i  = !wr && ar_h >= 0 && !rdone && (n >= ar_h + rsp_dly);
            r_resp_i   = rsp;
            r_data_i   = rdat;
            p_aw_hs = s_aw && aw_ready_i;
            p_w_hs  = s_w && w_ready_i;
            p_ar_hs = s_ar && ar_ready_i;
            if (p_aw_hs) begin aw_cnt++; aw_h = n; cap_aw_addr = aw_addr_o; cap_aw_prot = aw_prot_o; end
            if (p_w_hs)  begin w_cnt++;  w_h = n;  cap_w_data = w_data_o;   cap_w_strb = w_strb_o;   end
            if (p_ar_hs) begin ar_cnt++; ar_h = n; cap_ar_addr = ar_addr_o; cap_ar_prot = ar_prot_o; end
            if (s_b && b_valid_i) begin b_cnt++; bdone = 1; end
            if (s_r && r_valid_i) begin r_cnt++; rdone = 1; end
            p_aw = s_aw; p_w = s_w; p_ar = s_ar;
        end
        clear_axi_inputs();
        if (pr_cyc < 0) begin
            total++; bad++;
            $display("FAIL xfer_timeout: pready never seen within %0d cycles, required within budget", MAXCYC);
            psel_i = 1'b0; penable_i = 1'b0;
            return;
        end
        @(negedge clk_i);
        post_pr = pready_o; post_prdata = prdata_o; post_pslverr = pslverr_o;
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0;
        pprot_i = '0; pwdata_i = '0; pstrb_i = '0;
        clear_axi_inputs();
        repeat (3) @(negedge clk_i);
        total++;
        if ({pready_o, pslverr_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {pready_o, pslverr_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o});
        end
        total++;
        if ({prdata_o, aw_addr_o, aw_prot_o, w_data_o, w_strb_o, ar_addr_o, ar_prot_o} !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h required 0",
                     {prdata_o, aw_addr_o, aw_prot_o, w_data_o, w_strb_o, ar_addr_o, ar_prot_o});
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_write_basic();
        logic [383:0] e;
        @(negedge clk_i);
        run_xfer(1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 0, 0, 1, 2'b00, '0, -1);
        e = model(1, 0, 0, 0, 1);
        total++;
        if ({tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_pr} !== e || tr_pr !== 64'h8) begin
            bad++;
            $display("FAIL wr_basic_timing: got aw=%h w=%h b=%h pr=%h required %h (pready at t3)",
                     tr_aw, tr_w, tr_b, tr_pr, e);
        end
        total++;
        if ({got_prdata, got_pslverr} !== {32'h0, 1'b0}) begin
            bad++;
            $display("FAIL wr_basic_result: got prdata=%h pslverr=%b required 0/0", got_prdata, got_pslverr);
        end
        total++;
        if ({cap_aw_addr, cap_aw_prot, cap_w_data, cap_w_strb} !== {32'h1000_0010, 3'b010, 32'hDEAD_BEEF, 4'hF}) begin
            bad++;
            $display("FAIL wr_basic_fields: got addr=%h prot=%b data=%h strb=%h required 10000010/010/deadbeef/f",
                     cap_aw_addr, cap_aw_prot, cap_w_data, cap_w_strb);
        end
        total++;
        if ({post_pr, post_prdata, post_pslverr} !== '0) begin
            bad++;
            $display("FAIL wr_basic_after_done: got pready=%b prdata=%h pslverr=%b required all 0",
                     post_pr, post_prdata, post_pslverr);
        end
    endtask

    task automatic test_write_aw_delay();
        logic [383:0] e;
        @(negedge clk_i);
        run_xfer(1, 32'h1000_0044, 32'h1234_5678, 4'h3, 3'b000, 4, 1, 0, 1, 2'b00, '0, -1);
        e = model(1, 4, 1, 0, 1);
        total++;
        if ({tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_pr} !== e) begin
            bad++;
            $display("FAIL wr_aw_delay_timing: got aw=%h w=%h b=%h pr=%h required aw=%h w=%h b=%h pr=%h",
                     tr_aw, tr_w, tr_b, tr_pr, e[383:320], e[319:256], e[255:192], e[63:0]);
        end
        total++;
        if ({8'(aw_cnt), 8'(w_cnt), 8'(b_cnt), 8'(drop_err), post_pr} !== {8'd1, 8'd1, 8'd1, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL wr_aw_delay_counts: got aw=%0d w=%0d b=%0d drops=%0d post_pready=%b required 1/1/1/0/0",
                     aw_cnt, w_cnt, b_cnt, drop_err, post_pr);
        end
        total++;
        if ({cap_w_data, cap_w_strb} !== {32'h1234_5678, 4'h3}) begin
            bad++;
            $display("FAIL wr_data_held: got data=%h strb=%h required 12345678/3", cap_w_data, cap_w_strb);
        end
    endtask

    task automatic test_read_delay();
        logic [383:0] e;
        @(negedge clk_i);
        run_xfer(0, 32'h1000_0020, '0, '0, 3'b001, 0, 0, 0, 5, 2'b00, 32'hCAFE_F00D, -1);
        e = model(0, 0, 0, 0, 5);
        total++;
        if ({tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_pr} !== e) begin
            bad++;
            $display("FAIL rd_delay_timing: got ar=%h r=%h pr=%h required ar=%h r=%h pr=%h",
                     tr_ar, tr_r, tr_pr, e[191:128], e[127:64], e[63:0]);
        end
        total++;
        if ({got_prdata, got_pslverr} !== {32'hCAFE_F00D, 1'b0}) begin
            bad++;
            $display("FAIL rd_delay_result: got prdata=%h pslverr=%b required cafef00d/0", got_prdata, got_pslverr);
        end
        total++;
        if ({cap_ar_addr, cap_ar_prot, post_pr, post_prdata, post_pslverr} !== {32'h1000_0020, 3'b001, 34'b0}) begin
            bad++;
            $display("FAIL rd_delay_fields: got addr=%h prot=%b post=%b/%h/%b required 10000020/001/0/0/0",
                     cap_ar_addr, cap_ar_prot, post_pr, post_prdata, post_pslverr);
        end
    endtask

    task automatic test_errors();
        logic [DW-1:0] rd;
        rd = $urandom;
        @(negedge clk_i);
        run_xfer(0, 32'h2000_0000, '0, '0, 3'b000, 1, 0, 0, 2, 2'b10, rd, -1);
        total++;
        if ({got_prdata, got_pslverr, post_pslverr} !== {rd, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rd_slverr: got prdata=%h pslverr=%b post=%b required %h/1/0",
                     got_prdata, got_pslverr, post_pslverr, rd);
        end
        @(negedge clk_i);
        run_xfer(1, 32'h2000_0004, 32'h5555_AAAA, 4'hC, 3'b000, 0, 2, 0, 3, 2'b11, 32'hFFFF_FFFF, -1);
        total++;
        if ({got_prdata, got_pslverr, post_pslverr} !== {32'h0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL wr_decerr: got prdata=%h pslverr=%b post=%b required 0/1/0",
                     got_prdata, got_pslverr, post_pslverr);
        end
    endtask

    task automatic test_back_to_back();
        logic [383:0] e;
        @(negedge clk_i);
        run_xfer(1, 32'h3000_0000, 32'h0BAD_CAFE, 4'hF, 3'b000, 0, 0, 0, 1, 2'b00, '0, -1);
        e = model(1, 0, 0, 0, 1);
        total++;
        if ({tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_pr} !== e ||
            {8'(aw_cnt), 8'(w_cnt), 8'(b_cnt), 8'(ar_cnt), 8'(r_cnt)} !== {8'd1, 8'd1, 8'd1, 8'd0, 8'd0}) begin
            bad++;
            $display("FAIL b2b_write: got aw=%h w=%h b=%h ar=%h pr=%h cnt=%0d/%0d/%0d/%0d required %h single txn",
                     tr_aw, tr_w, tr_b, tr_ar, tr_pr, aw_cnt, w_cnt, b_cnt, ar_cnt, e);
        end
        run_xfer(0, 32'h3000_0004, '0, '0, 3'b000, 0, 0, 0, 1, 2'b00, 32'h7777_1111, -1);
        e = model(0, 0, 0, 0, 1);
        total++;
        if ({tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_pr} !== e ||
            {8'(aw_cnt), 8'(w_cnt), 8'(b_cnt), 8'(ar_cnt), 8'(r_cnt)} !== {8'd0, 8'd0, 8'd0, 8'd1, 8'd1}) begin
            bad++;
            $display("FAIL b2b_read: got aw=%h ar=%h r=%h pr=%h cnt=%0d/%0d required %h single txn",
                     tr_aw, tr_ar, tr_r, tr_pr, ar_cnt, r_cnt, e);
        end
        total++;
        if ({got_prdata, got_pslverr, post_pr} !== {32'h7777_1111, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL b2b_read_result: got %h/%b/%b required 77771111/0/0", got_prdata, got_pslverr, post_pr);
        end
    endtask

    task automatic test_reset_midflight();
        logic [383:0] e;
        @(negedge clk_i);
        run_xfer(1, 32'h4000_0000, 32'h1111_2222, 4'hF, 3'b000, 0, 0, 0, 10, 2'b00, '0, 3);
        e = model(1, 0, 0, 0, 10);
        total++;
        if (tr_b[3] !== e[192 + 3]) begin
            bad++;
            $display("FAIL rst_mid_precondition: got b_ready=%b at t3 required %b", tr_b[3], e[192 + 3]);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({pready_o, pslverr_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, prdata_o} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got ctrl=%b prdata=%h required all 0",
                     {pready_o, pslverr_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o}, prdata_o);
        end
        clear_axi_inputs();
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_xfer(0, 32'h4000_0008, '0, '0, 3'b000, 0, 0, 0, 2, 2'b00, 32'h600D_600D, -1);
        e = model(0, 0, 0, 0, 2);
        total++;
        if ({tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_pr} !== e ||
            {got_prdata, got_pslverr, post_pr} !== {32'h600D_600D, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_fresh_read: got ar=%h r=%h pr=%h prdata=%h required pr=%h prdata=600d600d",
                     tr_ar, tr_r, tr_pr, got_prdata, e[63:0]);
        end
    endtask

    task automatic test_random();
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data, rd;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        logic [1:0]    rsp;
        int            awd, wd, ard, rsd;
        logic [383:0]  e;
        @(negedge clk_i);
        for (int it = 0; it < 24; it++) begin
            wr = 1'($urandom_range(0, 1));
            addr = $urandom; data = $urandom; rd = $urandom;
            strb = SW'($urandom); prot = 3'($urandom); rsp = 2'($urandom);
            awd = $urandom_range(0, 3); wd = $urandom_range(0, 3);
            ard = $urandom_range(0, 3); rsd = $urandom_range(1, 4);
            run_xfer(wr, addr, data, strb, prot, awd, wd, ard, rsd, rsp, rd, -1);
            e = model(wr, awd, wd, ard, rsd);
            total++;
            if ({tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_pr} !== e || drop_err != 0) begin
                bad++;
                $display("FAIL rand_timing[%0d]: got aw=%h w=%h b=%h ar=%h r=%h pr=%h drops=%0d required %h",
                         it, tr_aw, tr_w, tr_b, tr_ar, tr_r, tr_pr, drop_err, e);
            end
            total++;
            if ({got_prdata, got_pslverr, post_pr, post_prdata, post_pslverr} !==
                {(wr ? 32'h0 : rd), rsp[1], 1'b0, 32'h0, 1'b0}) begin
                bad++;
                $display("FAIL rand_result[%0d]: got prdata=%h pslverr=%b post=%b/%h/%b required %h/%b/0/0/0",
                         it, got_prdata, got_pslverr, post_pr, post_prdata, post_pslverr,
                         (wr ? 32'h0 : rd), rsp[1]);
            end
            total++;
            if (wr ? ({cap_aw_addr, cap_aw_prot, cap_w_data, cap_w_strb} !== {addr, prot, data, strb})
                   : ({cap_ar_addr, cap_ar_prot} !== {addr, prot})) begin
                bad++;
                $display("FAIL rand_fields[%0d]: wr=%b got aw=%h/%b w=%h/%h ar=%h/%b required addr=%h prot=%b data=%h strb=%h",
                         it, wr, cap_aw_addr, cap_aw_prot, cap_w_data, cap_w_strb, cap_ar_addr, cap_ar_prot,
                         addr, prot, data, strb);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk_i);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_read_delay();
        test_errors();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
